// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronizes uart_rx, majority-votes each bit and presents frames on a ready/req handshake.
// Define UART_RX_BREAK_DET_EN to report all-zero frames as a break_det pulse instead of delivering them.
module uart_rx_deframer #(
    parameter int WIDTH       = 8,
    parameter int SAMPLE_RATE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cfg_parity,
    input  logic [1:0]       cfg_stop_bits,
    input  logic [15:0]      cfg_clk_div,
    input  logic             uart_rx,
    input  logic             rx_req,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun_err,
    output logic             break_det
);

    localparam int SW = $clog2(SAMPLE_RATE);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [SW-1:0] S_V0   = SW'(SAMPLE_RATE / 2 - 1);
    localparam logic [SW-1:0] S_V1   = SW'(SAMPLE_RATE / 2);
    localparam logic [SW-1:0] S_V2   = SW'(SAMPLE_RATE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(SAMPLE_RATE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [15:0]      tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]    samp_q, samp_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             stop_cnt_q, stop_cnt_d;
    logic [1:0]       vote_q, vote_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             perr_frame_q, perr_frame_d;
    logic             ferr_frame_q, ferr_frame_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_ready_q, rx_ready_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
`ifdef UART_RX_BREAK_DET_EN
    logic             zero_q, zero_d;
    logic             brk_wait_q, brk_wait_d;
    logic             break_q, break_d;
`endif

    logic [15:0] div_eff;
    logic        rx_s, tick, vote_now, maj, par_en, two_stop, pop;

    assign div_eff  = (cfg_clk_div == 16'd0) ? 16'd1 : cfg_clk_div;
    assign rx_s     = sync_q[1];
    assign tick     = (state_q != IDLE) && (tick_cnt_q >= div_eff - 16'd1);
    assign vote_now = tick && (samp_q == S_V2);
    assign maj      = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
    assign par_en   = (cfg_parity == 2'd1) || (cfg_parity == 2'd2);
    assign two_stop = cfg_stop_bits >= 2'd2;
    assign pop      = rx_req && rx_ready_q;

    always_comb begin
        state_d      = state_q;
        sync_d       = {sync_q[0], uart_rx};
        tick_cnt_d   = tick_cnt_q;
        samp_d       = samp_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        vote_d       = vote_q;
        shift_d      = shift_q;
        perr_frame_d = perr_frame_q;
        ferr_frame_d = ferr_frame_q;
        done_d       = 1'b0;
        rx_data_d    = rx_data_q;
        rx_ready_d   = rx_ready_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
`ifdef UART_RX_BREAK_DET_EN
        zero_d       = zero_q;
        brk_wait_d   = brk_wait_q;
        break_d      = 1'b0;
`endif

        if (state_q == IDLE) tick_cnt_d = 16'd0;
        else                 tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
        if (tick) samp_d = (samp_q == S_LAST) ? '0 : samp_q + 1'b1;
        if (tick && samp_q == S_V0) vote_d[0] = rx_s;
        if (tick && samp_q == S_V1) vote_d[1] = rx_s;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d      = START;
                    samp_d       = '0;
                    bit_cnt_d    = '0;
                    stop_cnt_d   = 1'b0;
                    perr_frame_d = 1'b0;
                    ferr_frame_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                    zero_d       = 1'b1;
                    brk_wait_d   = 1'b0;
`endif
                end
            end
            START: begin
                if (vote_now && maj)                  state_d = IDLE;
                else if (tick && samp_q == S_LAST)    state_d = DATA;
            end
            DATA: begin
                if (vote_now) shift_d = {maj, shift_q[WIDTH-1:1]};
                if (tick && samp_q == S_LAST) begin
                    if (bit_cnt_q == B_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = par_en ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (vote_now) perr_frame_d = ((^shift_q) ^ maj) != (cfg_parity == 2'd1);
                if (tick && samp_q == S_LAST) state_d = STOP;
            end
            STOP: begin
`ifdef UART_RX_BREAK_DET_EN
                if (brk_wait_q) begin
                    if (tick && rx_s) state_d = IDLE;
                end else
`endif
                begin
                    // Leave right after the last stop vote so a back-to-back start edge is not missed.
                    if (vote_now) begin
                        ferr_frame_d = ferr_frame_q | ~maj;
                        if (!two_stop || stop_cnt_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                            if (zero_q && !maj) begin
                                state_d    = STOP;
                                done_d     = 1'b0;
                                brk_wait_d = 1'b1;
                                break_d    = 1'b1;
                            end
`endif
                        end
                    end else if (tick && samp_q == S_LAST) begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef UART_RX_BREAK_DET_EN
        if (vote_now && maj) zero_d = 1'b0;
`endif

        // A completing frame may replace the held one only if it is being popped this cycle.
        if (done_q) begin
            if (!rx_ready_q || pop) begin
                rx_data_d    = shift_q;
                parity_err_d = perr_frame_q;
                frame_err_d  = ferr_frame_q;
                rx_ready_d   = 1'b1;
                if (pop) overrun_d = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (pop) begin
            rx_ready_d   = 1'b0;
            parity_err_d = 1'b0;
            frame_err_d  = 1'b0;
            overrun_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sync_q       <= 2'b11;
            tick_cnt_q   <= 16'd0;
            samp_q       <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            vote_q       <= 2'b11;
            shift_q      <= '0;
            perr_frame_q <= 1'b0;
            ferr_frame_q <= 1'b0;
            done_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_ready_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            zero_q       <= 1'b0;
            brk_wait_q   <= 1'b0;
            break_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            tick_cnt_q   <= tick_cnt_d;
            samp_q       <= samp_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            vote_q       <= vote_d;
            shift_q      <= shift_d;
            perr_frame_q <= perr_frame_d;
            ferr_frame_q <= ferr_frame_d;
            done_q       <= done_d;
            rx_data_q    <= rx_data_d;
            rx_ready_q   <= rx_ready_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_BREAK_DET_EN
            zero_q       <= zero_d;
            brk_wait_q   <= brk_wait_d;
            break_q      <= break_d;
`endif
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_ready    = rx_ready_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;
`ifdef UART_RX_BREAK_DET_EN
    assign break_det   = break_q;
`else
    assign break_det   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer: frames are serialized bit by bit, expected bytes queued, and
// compared on each pop. Build with UART_RX_BREAK_DET_EN to exercise the break path.
module tb_uart_rx_deframer;

    localparam int DIV = 6;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cfg_parity;
    logic [1:0]  cfg_stop_bits;
    logic [15:0] cfg_clk_div;
    logic        uart_rx;
    logic        rx_req;
    logic [7:0]  rx_data;
    logic        rx_ready, parity_err, frame_err, overrun_err, break_det;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   bit_clks = 16 * DIV;
    int   brk_count = 0;
    logic model_ready = 1'b0;
    logic model_ovr = 1'b0;

    uart_rx_deframer #(.WIDTH(8), .SAMPLE_RATE(16)) dut (
        .clk(clk), .rst(rst), .cfg_parity(cfg_parity), .cfg_stop_bits(cfg_stop_bits),
        .cfg_clk_div(cfg_clk_div), .uart_rx(uart_rx), .rx_req(rx_req), .rx_data(rx_data),
        .rx_ready(rx_ready), .parity_err(parity_err), .frame_err(frame_err),
        .overrun_err(overrun_err), .break_det(break_det)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (break_det === 1'b1) brk_count++;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    endtask

    // Serialize one frame using the current cfg; an optional short inversion (spike) lands at clock offset spike_at.
    task automatic applyStimulus(input logic [7:0] data, input logic flip7, input logic pflip,
                                 input logic stop1, input logic stop2, input int spike_at, input logic upd);
        logic [7:0] sent;
        logic       fr [12];
        logic       pbit, par_en, even, two, b;
        int         n, ones;
        exp_t       e;
        sent   = data ^ {flip7, 7'b0};
        par_en = (cfg_parity == 2'd1) || (cfg_parity == 2'd2);
        even   = (cfg_parity == 2'd2);
        two    = (cfg_stop_bits >= 2'd2);
        pbit   = (^data) ^ !even ^ pflip;
        fr[0]  = 1'b0;
        for (int i = 0; i < 8; i++) fr[1+i] = sent[i];
        n = 9;
        if (par_en) begin fr[n] = pbit; n++; end
        fr[n] = stop1; n++;
        if (two) begin fr[n] = stop2; n++; end
        for (int c = 0; c < n * bit_clks; c++) begin
            @(negedge clk);
            b = fr[c / bit_clks];
            if (spike_at >= 0 && c >= spike_at && c < spike_at + 2 * DIV) b = ~b;
            uart_rx = b;
        end
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (bit_clks) @(negedge clk);
        ones   = $countones(sent) + (par_en ? int'(pbit) : 0);
        e.data = sent;
        e.perr = par_en && (((ones % 2) == 1) == even);
        e.ferr = !stop1 || (two && !stop2);
        if (upd) begin
            if (model_ready) model_ovr = 1'b1;
            else begin exp_q.push_back(e); model_ready = 1'b1; end
        end
    endtask

    task automatic popAndCheck(input string tag);
        exp_t e;
        int   waited;
        waited = 0;
        e = '0;
        @(negedge clk);
        while (rx_ready !== 1'b1 && waited < 16 * bit_clks) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, ".ready"}, 32'(rx_ready), 32'd1);
        checkOutput({tag, ".sb"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        checkOutput({tag, ".data"}, 32'(rx_data), 32'(e.data));
        checkOutput({tag, ".perr"}, 32'(parity_err), 32'(e.perr));
        checkOutput({tag, ".ferr"}, 32'(frame_err), 32'(e.ferr));
        checkOutput({tag, ".ovr"}, 32'(overrun_err), 32'(model_ovr));
        rx_req = 1'b1;
        @(negedge clk);
        rx_req = 1'b0;
        checkOutput({tag, ".popflags"}, 32'({rx_ready, parity_err, frame_err, overrun_err}), 32'd0);
        checkOutput({tag, ".hold"}, 32'(rx_data), 32'(e.data));
        model_ready = 1'b0;
        model_ovr   = 1'b0;
    endtask

    initial begin
        #20ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int brk_before;
        rst = 1'b1; uart_rx = 1'b1; rx_req = 1'b0;
        cfg_parity = 2'd0; cfg_stop_bits = 2'd0; cfg_clk_div = 16'(DIV);
        repeat (5) @(negedge clk);
        checkOutput("reset.outs", 32'({rx_data, rx_ready, parity_err, frame_err, overrun_err, break_det}), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset.idle", 32'({rx_ready, overrun_err}), 32'd0);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(8'(i), 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b1);
            popAndCheck($sformatf("clean%0d", i));
        end

        cfg_clk_div = 16'd0; bit_clks = 16;
        applyStimulus(8'h96, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b1);
        popAndCheck("div0");
        cfg_clk_div = 16'(DIV); bit_clks = 16 * DIV;

        cfg_parity = 2'd2;
        applyStimulus(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b1);
        popAndCheck("even.ok");
        applyStimulus(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, -1, 1'b1);
        popAndCheck("even.bad");
        applyStimulus(8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b1);
        popAndCheck("even.flip7");
        cfg_parity = 2'd1;
        applyStimulus(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b1);
        popAndCheck("odd.ok");
        cfg_parity = 2'd0;

        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1);
        popAndCheck("stop.low");
        cfg_stop_bits = 2'd2;
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b1);
        popAndCheck("stop2.low");
        cfg_stop_bits = 2'd0;

        brk_before = brk_count;
        @(negedge clk); uart_rx = 1'b0;
        repeat (5 * DIV) @(negedge clk);
        uart_rx = 1'b1;
        repeat (12 * bit_clks) @(negedge clk);
        checkOutput("glitch.ready", 32'(rx_ready), 32'd0);
        checkOutput("glitch.brk", 32'(brk_count - brk_before), 32'd0);
        applyStimulus(8'hF0, 1'b0, 1'b0, 1'b1, 1'b1, 5 * bit_clks + 9 * DIV + 3, 1'b1);
        popAndCheck("spike");

        applyStimulus(8'h11, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b1);
        applyStimulus(8'h22, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b1);
        popAndCheck("overrun");

        applyStimulus(8'h55, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b1);
        checkOutput("held.ready", 32'(rx_ready), 32'd1);
        checkOutput("held.data", 32'(rx_data), 32'(exp_q[0].data));
        void'(exp_q.pop_front());
        exp_q.push_back('{data: 8'h33, perr: 1'b0, ferr: 1'b0});
        fork
            applyStimulus(8'h33, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0);
            begin
                repeat (4 + 154 * DIV) @(negedge clk);
                rx_req = 1'b1;
                @(negedge clk);
                rx_req = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    checkOutput("samecycle.ready", 32'(rx_ready), 32'd1);
                    @(negedge clk);
                end
                checkOutput("samecycle.data", 32'(rx_data), 32'h33);
                checkOutput("samecycle.ovr", 32'(overrun_err), 32'd0);
            end
        join
        popAndCheck("samecycle");

        @(negedge clk); uart_rx = 1'b0;
        repeat (bit_clks) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * bit_clks) @(negedge clk);
        rst = 1'b1;
        exp_q.delete(); model_ready = 1'b0; model_ovr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12 * bit_clks) @(negedge clk);
        checkOutput("midreset.outs", 32'({rx_ready, parity_err, frame_err, overrun_err}), 32'd0);
        applyStimulus(8'h44, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b1);
        popAndCheck("after.reset");

        brk_before = brk_count;
`ifdef UART_RX_BREAK_DET_EN
        @(negedge clk); uart_rx = 1'b0;
        repeat (12 * bit_clks) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4 * bit_clks) @(negedge clk);
        checkOutput("break.pulses", 32'(brk_count - brk_before), 32'd1);
        checkOutput("break.ready", 32'(rx_ready), 32'd0);
        applyStimulus(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b1);
        popAndCheck("after.break");
`else
        exp_q.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1});
        model_ready = 1'b1;
        fork
            begin
                @(negedge clk); uart_rx = 1'b0;
                repeat (12 * bit_clks) @(negedge clk);
                uart_rx = 1'b1;
            end
            popAndCheck("break");
        join
        repeat (14 * bit_clks) @(negedge clk);
        if (rx_ready === 1'b1) begin
            rx_req = 1'b1;
            @(negedge clk);
            rx_req = 1'b0;
        end
        repeat (2) @(negedge clk);
        checkOutput("break.drained", 32'({rx_ready, overrun_err}), 32'd0);
        checkOutput("break.nopulse", 32'(brk_count - brk_before), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
